// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   state_t     : scanner FSM states
//   key_code_t  : 4-bit key code pushed to the FIFO
//   onehot_t    : result of onehot_idx (valid flag + bit index)
//   KEYMAP      : row-major key code table, index = row*4 + col
//   onehot_idx  : index of the single set bit of a 4-bit column vector
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    WAIT_DB = 2'd1,
    HELD    = 2'd2
  } state_t;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } onehot_t;

  // Row-major layout:  1 2 3 A / 4 5 6 B / 7 8 9 C / E(*) 0 F(#) D
  localparam key_code_t KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic onehot_t onehot_idx(input logic [3:0] v);
    onehot_t r;
    r.valid = 1'b0;
    r.idx   = 2'd0;
    case (v)
      4'b0001: begin r.valid = 1'b1; r.idx = 2'd0; end
      4'b0010: begin r.valid = 1'b1; r.idx = 2'd1; end
      4'b0100: begin r.valid = 1'b1; r.idx = 2'd2; end
      4'b1000: begin r.valid = 1'b1; r.idx = 2'd3; end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small key-code FIFO with a combinational head read.
//   clk, n_reset : clock, asynchronous active-low reset (empties FIFO, clears memory)
//   push, din    : write request and 4-bit data
//   pop          : read request (ignored when empty)
//   dout         : head entry, mem[rd_ptr]
//   full, count  : occupancy status; count is log2(DEPTH)+1 bits
module key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic                     pop,
  input  key_code_t                din,
  output key_code_t                dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  key_code_t       mem_q [DEPTH];
  key_code_t       mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty;
  logic            pop_ok;
  logic            push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad row scanner and key encoder. Rotates a one-hot row drive,
// freezes on column activity, waits for the debouncer to confirm, then
// encodes the pressed key and queues it in a FIFO.
//   clk, n_reset  : clock, asynchronous active-low reset
//   cols_raw      : raw active-high column inputs
//   db_key        : debounced any-key level from the debouncer
//   col_captured  : column latched by the debouncer
//   rows          : one-hot row drive
//   key_any       : OR of cols_raw, feeds the debouncer button input
//   out_valid/out_ready/out_code : FIFO head handshake
//   overflow      : sticky, a confirmed press was dropped on a full FIFO
//   multi_key     : one-cycle pulse, confirm with a non-one-hot column
//   ovf_clr       : clears overflow (a same-cycle set wins)
//
// state   | meaning
// SCAN    | rotating rows every SCAN_DIV cycles, watching the columns
// WAIT_DB | row frozen, waiting for debouncer confirm or timeout
// HELD    | press handled, waiting for the key to be released
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int TIMEOUT  = 1024,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] cols_raw,
  input  logic       db_key,
  input  logic [3:0] col_captured,
  output logic [3:0] rows,
  output logic       key_any,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_code,
  output logic       overflow,
  output logic       multi_key,
  input  logic       ovf_clr
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [3:0]         rows_q, rows_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               overflow_q, overflow_d;
  logic               multi_key_q, multi_key_d;

  onehot_t            oh;
  key_code_t          push_code;
  logic               push_req;
  logic               ovf_set;
  logic               fifo_full;
  logic [$clog2(DEPTH):0] fifo_count;

  assign key_any   = |cols_raw;
  assign oh        = onehot_idx(col_captured);
  assign push_code = KEYMAP[{row_idx_q, oh.idx}];

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    row_idx_d   = row_idx_q;
    div_d       = div_q;
    tmo_d       = tmo_q;
    push_req    = 1'b0;
    multi_key_d = 1'b0;
    case (state_q)
      SCAN: begin
        // Column activity beats a same-cycle row rotation so the row that
        // saw the key stays driven.
        if (key_any) begin
          state_d = WAIT_DB;
          tmo_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d     = '0;
          rows_d    = {rows_q[2:0], rows_q[3]};
          row_idx_d = row_idx_q + 2'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      WAIT_DB: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (db_key) begin
          state_d = HELD;
          if (oh.valid) begin
            push_req = 1'b1;
          end else begin
            multi_key_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = SCAN;
          div_d   = '0;
        end
      end
      HELD: begin
        if (!db_key) begin
          state_d   = SCAN;
          div_d     = '0;
          rows_d    = {rows_q[2:0], rows_q[3]};
          row_idx_d = row_idx_q + 2'd1;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase

    // When full, the head is present, so a ready consumer frees a slot this cycle.
    ovf_set    = push_req & fifo_full & ~out_ready;
    overflow_d = ovf_set | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= SCAN;
      rows_q      <= 4'b0001;
      row_idx_q   <= 2'd0;
      div_q       <= '0;
      tmo_q       <= '0;
      overflow_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      row_idx_q   <= row_idx_d;
      div_q       <= div_d;
      tmo_q       <= tmo_d;
      overflow_q  <= overflow_d;
      multi_key_q <= multi_key_d;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push_req),
    .pop     (out_ready),
    .din     (push_code),
    .dout    (out_code),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign rows      = rows_q;
  assign overflow  = overflow_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
module tb_keypad_scan_decoder;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] cols_raw;
  logic       db_key;
  logic [3:0] col_captured;
  logic [3:0] rows;
  logic       key_any;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_code;
  logic       overflow;
  logic       multi_key;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         row;
    logic [3:0] cols;
    logic [3:0] code;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  keypad_scan_decoder dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .cols_raw     (cols_raw),
    .db_key       (db_key),
    .col_captured (col_captured),
    .rows         (rows),
    .key_any      (key_any),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .overflow     (overflow),
    .multi_key    (multi_key),
    .ovf_clr      (ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row(input int row);
    logic [3:0] target;
    int n;
    target = 4'b0001 << row;
    n = 0;
    while (rows !== target && n < 100) begin
      tick();
      n++;
    end
    if (rows !== target) begin
      checks++;
      errors++;
      $display("FAIL wait_row: rows %b never reached %b", rows, target);
    end
  endtask

  // Leaves the DUT in HELD with db_key still high.
  task automatic press(input int row, input logic [3:0] cols, input int settle,
                       input logic rdy, input logic clr);
    wait_row(row);
    cols_raw = cols;
    tick();
    repeat (settle) tick();
    db_key       = 1'b1;
    col_captured = cols;
    out_ready    = rdy;
    ovf_clr      = clr;
    tick();
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic release_key();
    db_key       = 1'b0;
    col_captured = 4'b0000;
    cols_raw     = 4'b0000;
    tick();
  endtask

  task automatic pop_expect(input string name, input logic [3:0] code);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_code"}, out_code, code);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rows;
    logic       ok;

    vecs[0]  = '{0, 4'b0001, 4'h1};
    vecs[1]  = '{0, 4'b0010, 4'h2};
    vecs[2]  = '{0, 4'b0100, 4'h3};
    vecs[3]  = '{0, 4'b1000, 4'hA};
    vecs[4]  = '{1, 4'b0001, 4'h4};
    vecs[5]  = '{1, 4'b0010, 4'h5};
    vecs[6]  = '{1, 4'b0100, 4'h6};
    vecs[7]  = '{1, 4'b1000, 4'hB};
    vecs[8]  = '{2, 4'b0001, 4'h7};
    vecs[9]  = '{2, 4'b0010, 4'h8};
    vecs[10] = '{2, 4'b0100, 4'h9};
    vecs[11] = '{2, 4'b1000, 4'hC};
    vecs[12] = '{3, 4'b0001, 4'hE};
    vecs[13] = '{3, 4'b0010, 4'h0};
    vecs[14] = '{3, 4'b0100, 4'hF};
    vecs[15] = '{3, 4'b1000, 4'hD};

    n_reset      = 1'b0;
    cols_raw     = 4'b0000;
    db_key       = 1'b0;
    col_captured = 4'b0000;
    out_ready    = 1'b0;
    ovf_clr      = 1'b0;

    // Reset values and idle rotation
    #12;
    chk("rst_rows", rows, 4'b0001);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_code", out_code, 4'h0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_multi", multi_key, 1'b0);
    chk("key_any_idle", key_any, 1'b0);
    n_reset = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      exp_rows = 4'b0001 << ((k / 16) % 4);
      chk("idle_rows", rows, exp_rows);
    end
    chk("idle_valid", out_valid, 1'b0);

    // Key 5 with full debounce settle and a long hold
    wait_row(1);
    cols_raw = 4'b0010;
    #1;
    chk("key_any_active", key_any, 1'b1);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (rows !== 4'b0010 || out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("k5_frozen_settle", ok, 1'b1);
    db_key       = 1'b1;
    col_captured = 4'b0010;
    tick();
    chk("k5_valid", out_valid, 1'b1);
    chk("k5_code", out_code, 4'h5);
    chk("k5_rows", rows, 4'b0010);
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rows !== 4'b0010 || out_valid !== 1'b1 || out_code !== 4'h5) ok = 1'b0;
    end
    chk("k5_hold_stable", ok, 1'b1);
    release_key();
    chk("k5_release_rows", rows, 4'b0100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("k5_single_entry", out_valid, 1'b0);

    // Glitch: no confirm, timeout after 1024 cycles in WAIT_DB
    cols_raw = 4'b0001;
    tick();
    for (int i = 1; i <= 1040; i++) begin
      if (i == 4) cols_raw = 4'b0000;
      tick();
      if (i == 1023) chk("glitch_frozen", rows, 4'b0100);
      if (i == 1039) chk("glitch_div_clr", rows, 4'b0100);
      if (i == 1040) chk("glitch_resume", rows, 4'b1000);
    end
    chk("glitch_no_push", out_valid, 1'b0);

    // Full keymap
    for (int v = 0; v < 16; v++) begin
      press(vecs[v].row, vecs[v].cols, 3, 1'b0, 1'b0);
      chk("map_valid", out_valid, 1'b1);
      chk("map_code", out_code, vecs[v].code);
      release_key();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("map_drained", out_valid, 1'b0);
    end

    // Non-one-hot capture
    press(1, 4'b0011, 3, 1'b0, 1'b0);
    chk("multi_pulse", multi_key, 1'b1);
    chk("multi_no_push", out_valid, 1'b0);
    tick();
    chk("multi_one_cycle", multi_key, 1'b0);
    release_key();
    chk("multi_still_empty", out_valid, 1'b0);

    // Five presses into a 4-deep FIFO
    press(0, 4'b0001, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b0010, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b0100, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b1000, 3, 1'b0, 1'b0);
    chk("ovf_not_yet", overflow, 1'b0);
    release_key();
    press(1, 4'b0001, 3, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    release_key();
    pop_expect("pop0", 4'h1);
    pop_expect("pop1", 4'h2);
    pop_expect("pop2", 4'h3);
    pop_expect("pop3", 4'hA);
    chk("pop_empty", out_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Full FIFO, push of # with a same-cycle pop
    press(0, 4'b0001, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b0010, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b0100, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b1000, 3, 1'b0, 1'b0); release_key();
    press(3, 4'b0100, 3, 1'b1, 1'b0);
    chk("full_pp_ovf", overflow, 1'b0);
    release_key();
    pop_expect("fpp0", 4'h2);
    pop_expect("fpp1", 4'h3);
    pop_expect("fpp2", 4'hA);
    pop_expect("fpp3", 4'hF);
    chk("fpp_empty", out_valid, 1'b0);

    // Overflow set beats ovf_clr, then async reset while HELD
    press(0, 4'b0001, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b0010, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b0100, 3, 1'b0, 1'b0); release_key();
    press(0, 4'b1000, 3, 1'b0, 1'b0); release_key();
    press(2, 4'b0100, 3, 1'b0, 1'b1);
    chk("ovf_set_priority", overflow, 1'b1);
    chk("held_rows", rows, 4'b0100);
    #2;
    n_reset = 1'b0;
    #1;
    chk("arst_rows", rows, 4'b0001);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_code", out_code, 4'h0);
    chk("arst_overflow", overflow, 1'b0);
    chk("arst_multi", multi_key, 1'b0);
    db_key       = 1'b0;
    col_captured = 4'b0000;
    cols_raw     = 4'b0000;
    #1;
    n_reset = 1'b1;
    repeat (15) tick();
    chk("post_rst_row0", rows, 4'b0001);
    tick();
    chk("post_rst_row1", rows, 4'b0010);
    chk("post_rst_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
